reg_file_nzcv: RTL and testbench



---
 rtl/cpu_pkg.sv | 29 ++
 rtl/reg_file_nzcv_if.sv | 37 +++
 rtl/reg_file_nzcv_read_port.sv | 34 +++
 rtl/reg_file_nzcv.sv | 71 +++++++
 tb/tb_reg_file_nzcv.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared CPU datapath constants, ALU opcodes and the NZCV flag type.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int REGISTER_LENGTH = 64;
  localparam int ADDR_LENGTH     = 5;
  localparam logic [ADDR_LENGTH-1:0] XZR_INDEX = 5'd31;

  localparam logic [2:0] ALU_PASS_B   = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic [2:0] ALU_SUBTRACT = 3'b011;
  localparam logic [2:0] ALU_AND      = 3'b100;
  localparam logic [2:0] ALU_OR       = 3'b101;
  localparam logic [2:0] ALU_XOR      = 3'b110;

  // Field order gives bit3=N, bit2=Z, bit1=C, bit0=V when packed.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_nzcv_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_nzcv_if                                                     |
// | Read/write/flag bus between the pipeline and the register file.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface reg_file_nzcv_if;
  import cpu_pkg::*;

  logic [ADDR_LENGTH-1:0]     ReadAddrA_i;
  logic [ADDR_LENGTH-1:0]     ReadAddrB_i;
  logic [REGISTER_LENGTH-1:0] ReadDataA_o;
  logic [REGISTER_LENGTH-1:0] ReadDataB_o;
  logic                       WriteEn_i;
  logic [ADDR_LENGTH-1:0]     WriteAddr_i;
  logic [REGISTER_LENGTH-1:0] WriteData_i;
  logic                       FlagWriteEn_i;
  logic                       zero_i;
  logic                       overflow_i;
  logic                       carryout_i;
  logic                       negative_i;
  logic [3:0]                 Flags_o;

  modport master (
    output ReadAddrA_i, ReadAddrB_i, WriteEn_i, WriteAddr_i, WriteData_i,
    output FlagWriteEn_i, zero_i, overflow_i, carryout_i, negative_i,
    input  ReadDataA_o, ReadDataB_o, Flags_o
  );

  modport slave (
    input  ReadAddrA_i, ReadAddrB_i, WriteEn_i, WriteAddr_i, WriteData_i,
    input  FlagWriteEn_i, zero_i, overflow_i, carryout_i, negative_i,
    output ReadDataA_o, ReadDataB_o, Flags_o
  );

endinterface
`default_nettype wire

// File: rtl/reg_file_nzcv_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_read_port                                                        |
// | One read port: zero-register forcing plus same-cycle write bypass.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_read_port
  import cpu_pkg::*;
(
  input  wire logic                       rst,
  input  wire logic [ADDR_LENGTH-1:0]     addr,
  input  wire logic [REGISTER_LENGTH-1:0] stored,
  input  wire logic                       write_en,
  input  wire logic [ADDR_LENGTH-1:0]     write_addr,
  input  wire logic [REGISTER_LENGTH-1:0] write_data,
  output logic      [REGISTER_LENGTH-1:0] data
);

  logic w_bypass;

  // A write that reset will discard must not be forwarded either.
  assign w_bypass = !rst && write_en && (write_addr == addr);

  always_comb begin
    data = stored;
    if (addr == XZR_INDEX) begin
      data = '0;
    end else if (w_bypass) begin
      data = write_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_nzcv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_nzcv                                                        |
// | 32x64 GPR file (X31 = XZR) with two bypassed read ports and NZCV.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_file_nzcv
  import cpu_pkg::*;
#(
  parameter int REGISTER_LENGTH = 64,
  parameter int REG_COUNT       = 32,
  parameter int ADDR_LENGTH     = 5
) (
  input  wire logic       clk_i,
  input  wire logic       reset_i,
  reg_file_nzcv_if.slave  bus
);

  logic [REGISTER_LENGTH-1:0] r_regs [REG_COUNT];
  nzcv_t                      r_flags;

  logic [ADDR_LENGTH-1:0]     w_write_addr;
  logic [REGISTER_LENGTH-1:0] w_write_data;

  assign w_write_addr = bus.WriteAddr_i;
  assign w_write_data = bus.WriteData_i;

  // The XZR slot is cleared on reset and never written, so it stays zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.WriteEn_i && (w_write_addr != XZR_INDEX)) begin
      r_regs[w_write_addr] <= w_write_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_flags <= '0;
    end else if (bus.FlagWriteEn_i) begin
      r_flags <= '{n: bus.negative_i, z: bus.zero_i,
                   c: bus.carryout_i, v: bus.overflow_i};
    end
  end

  assign bus.Flags_o = r_flags;

  reg_read_port u_port_a (
    .rst        (reset_i),
    .addr       (bus.ReadAddrA_i),
    .stored     (r_regs[bus.ReadAddrA_i]),
    .write_en   (bus.WriteEn_i),
    .write_addr (w_write_addr),
    .write_data (w_write_data),
    .data       (bus.ReadDataA_o)
  );

  reg_read_port u_port_b (
    .rst        (reset_i),
    .addr       (bus.ReadAddrB_i),
    .stored     (r_regs[bus.ReadAddrB_i]),
    .write_en   (bus.WriteEn_i),
    .write_addr (w_write_addr),
    .write_data (w_write_data),
    .data       (bus.ReadDataB_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_nzcv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_file_nzcv                                                     |
// | Directed self-checking bench for reg_file_nzcv.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_reg_file_nzcv;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  reg_file_nzcv_if bus ();

  reg_file_nzcv dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst               = 1'b1;
    bus.ReadAddrA_i   = '0;
    bus.ReadAddrB_i   = '0;
    bus.WriteEn_i     = 1'b0;
    bus.WriteAddr_i   = '0;
    bus.WriteData_i   = '0;
    bus.FlagWriteEn_i = 1'b0;
    bus.zero_i        = 1'b0;
    bus.overflow_i    = 1'b0;
    bus.carryout_i    = 1'b0;
    bus.negative_i    = 1'b0;
    tick();
    rst = 1'b0;

    // Reset state
    bus.ReadAddrA_i = 5'd0; bus.ReadAddrB_i = 5'd15; #1;
    check("rst_x0",  bus.ReadDataA_o, 64'h0);
    check("rst_x15", bus.ReadDataB_o, 64'h0);
    bus.ReadAddrA_i = 5'd30; #1;
    check("rst_x30", bus.ReadDataA_o, 64'h0);
    check("rst_flags", {60'h0, bus.Flags_o}, 64'h0);

    // Write and readback
    bus.WriteEn_i = 1'b1; bus.WriteAddr_i = 5'd5;
    bus.WriteData_i = 64'hDEAD_BEEF_0123_4567;
    tick();
    bus.WriteEn_i = 1'b0; bus.WriteData_i = 64'h0;
    bus.ReadAddrA_i = 5'd5; bus.ReadAddrB_i = 5'd6; #1;
    check("wr_x5", bus.ReadDataA_o, 64'hDEAD_BEEF_0123_4567);
    check("wr_x6", bus.ReadDataB_o, 64'h0);

    // Zero register ignores writes and never bypasses
    bus.WriteEn_i = 1'b1; bus.WriteAddr_i = 5'd31;
    bus.WriteData_i = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.ReadAddrA_i = 5'd31; bus.ReadAddrB_i = 5'd31; #1;
    check("xzr_same_a", bus.ReadDataA_o, 64'h0);
    check("xzr_same_b", bus.ReadDataB_o, 64'h0);
    tick();
    bus.WriteEn_i = 1'b0; #1;
    check("xzr_after", bus.ReadDataA_o, 64'h0);

    // Bypass on both ports
    bus.WriteEn_i = 1'b1; bus.WriteAddr_i = 5'd7; bus.WriteData_i = 64'h1;
    tick();
    bus.WriteEn_i = 1'b0; bus.ReadAddrA_i = 5'd7; bus.ReadAddrB_i = 5'd7; #1;
    check("x7_hold1", bus.ReadDataA_o, 64'h1);
    bus.WriteEn_i = 1'b1; bus.WriteData_i = 64'h2; #1;
    check("byp_a_pre", bus.ReadDataA_o, 64'h2);
    check("byp_b_pre", bus.ReadDataB_o, 64'h2);
    tick();
    bus.WriteEn_i = 1'b0; bus.WriteData_i = 64'h0; #1;
    check("byp_a_post", bus.ReadDataA_o, 64'h2);
    check("byp_b_post", bus.ReadDataB_o, 64'h2);

    // Flags: capture, no bypass, hold
    bus.FlagWriteEn_i = 1'b1;
    bus.negative_i = 1'b1; bus.zero_i = 1'b0;
    bus.carryout_i = 1'b1; bus.overflow_i = 1'b0; #1;
    check("flags_nobyp", {60'h0, bus.Flags_o}, 64'h0);
    tick();
    bus.FlagWriteEn_i = 1'b0;
    bus.negative_i = 1'b0; bus.zero_i = 1'b1;
    bus.carryout_i = 1'b0; bus.overflow_i = 1'b1; #1;
    check("flags_cap", {60'h0, bus.Flags_o}, 64'hA);
    tick();
    check("flags_hold", {60'h0, bus.Flags_o}, 64'hA);

    // Write and flag capture in the same cycle
    bus.WriteEn_i = 1'b1; bus.WriteAddr_i = 5'd9;
    bus.WriteData_i = 64'h0123_4567_89AB_CDEF;
    bus.FlagWriteEn_i = 1'b1;
    bus.negative_i = 1'b0; bus.zero_i = 1'b1;
    bus.carryout_i = 1'b1; bus.overflow_i = 1'b1;
    tick();
    bus.WriteEn_i = 1'b0; bus.FlagWriteEn_i = 1'b0;
    bus.ReadAddrA_i = 5'd9; bus.ReadAddrB_i = 5'd5; #1;
    check("both_x9", bus.ReadDataA_o, 64'h0123_4567_89AB_CDEF);
    check("both_flags", {60'h0, bus.Flags_o}, 64'h7);
    check("x5_kept", bus.ReadDataB_o, 64'hDEAD_BEEF_0123_4567);

    // Reset wins over concurrent write and flag capture
    bus.WriteEn_i = 1'b1; bus.WriteAddr_i = 5'd3; bus.WriteData_i = 64'h11;
    tick();
    bus.WriteEn_i = 1'b0; bus.ReadAddrA_i = 5'd3; #1;
    check("x3_pre", bus.ReadDataA_o, 64'h11);
    rst = 1'b1;
    bus.WriteEn_i = 1'b1; bus.WriteData_i = 64'h55;
    bus.FlagWriteEn_i = 1'b1;
    bus.negative_i = 1'b1; bus.zero_i = 1'b1;
    bus.carryout_i = 1'b1; bus.overflow_i = 1'b1; #1;
    check("rst_nobyp", bus.ReadDataA_o, 64'h11);
    tick();
    rst = 1'b0; bus.WriteEn_i = 1'b0; bus.FlagWriteEn_i = 1'b0; #1;
    check("rst_x3", bus.ReadDataA_o, 64'h0);
    check("rst_x5", bus.ReadDataB_o, 64'h0);
    check("rst_flags2", {60'h0, bus.Flags_o}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
